// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path and its ALU.
package mips_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUOP_W  = 4;
  localparam int unsigned STATE_W  = 4;

  // Control FSM states; the encoding is also exported on the State debug port.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Opcode field values (IR[31:26]).
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  // Funct field values for R-type (IR[5:0]).
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  // ALU operation codes, identical on both sides of the ALU interface.
  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0100,
    ALU_OR  = 4'b0101,
    ALU_XOR = 4'b0110,
    ALU_NOR = 4'b0111,
    ALU_SLT = 4'b1010
  } aluop_t;

  // Datapath mux select values.
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control word produced by the FSM each cycle.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    aluop_t     aluop;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type Funct decode to ALU operation plus legality flag.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [FUNCT_W-1:0] funct,
  output aluop_t             aluop,
  output logic               legal
);

  // Map each supported Funct to its ALU code; anything else is flagged illegal.
  always_comb begin
    aluop = ALU_ADD;
    legal = 1'b1;
    case (funct)
      FN_ADD:  aluop = ALU_ADD;
      FN_SUB:  aluop = ALU_SUB;
      FN_AND:  aluop = ALU_AND;
      FN_OR:   aluop = ALU_OR;
      FN_XOR:  aluop = ALU_XOR;
      FN_NOR:  aluop = ALU_NOR;
      FN_SLT:  aluop = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
module multicycle_control
  import mips_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic [FUNCT_W-1:0]  Funct,
  input  logic                Z,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCEn,
  output logic                RegDst,
  output logic                MemtoReg,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Illegal,
  output logic [STATE_W-1:0]  State
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;
  aluop_t fn_aluop;
  logic   fn_legal;

  alu_decoder u_alu_decoder (
    .funct (Funct),
    .aluop (fn_aluop),
    .legal (fn_legal)
  );

  // State register; reset parks the machine in FETCH.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and control word decode from the current state.
  always_comb begin
    state_d    = state_q;
    ctrl       = '0;
    ctrl.aluop = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl.alusrcb = SRCB_IMM_SH;
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (fn_legal) begin
              state_d = S_EXECUTE;
            end else begin
              ctrl.illegal = 1'b1;
              state_d      = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
        state_d   = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = fn_aluop;
        state_d      = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        state_d      = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Drive ports from the control word; Z=0 means the beq operands matched.
  assign IorD     = ctrl.iord;
  assign MemWrite = ctrl.memwrite;
  assign IRWrite  = ctrl.irwrite;
  assign PCEn     = ctrl.pcwrite | (ctrl.branch & ~Z);
  assign RegDst   = ctrl.regdst;
  assign MemtoReg = ctrl.memtoreg;
  assign RegWrite = ctrl.regwrite;
  assign ALUSrcA  = ctrl.alusrca;
  assign ALUSrcB  = ctrl.alusrcb;
  assign PCSrc    = ctrl.pcsrc;
  assign ALUOp    = ctrl.aluop;
  assign Illegal  = ctrl.illegal;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, reset corner case, random instructions.
module tb_multicycle_control;
  import mips_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Z;
  logic       IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUOp, State;

  multicycle_control dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .Opcode   (Opcode),
    .Funct    (Funct),
    .Z        (Z),
    .IorD     (IorD),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .PCEn     (PCEn),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .PCSrc    (PCSrc),
    .ALUOp    (ALUOp),
    .Illegal  (Illegal),
    .State    (State)
  );

  always #5 CLK = ~CLK;

  // Observable output bundle, compared as one vector per cycle.
  typedef struct packed {
    logic [3:0] state;
    logic       iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluop;
    logic       illegal;
  } obs_t;

  typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL} iclass_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [3:0] cycles;
    logic [3:0] exec_op;
    logic       illegal;
  } vec_t;

  localparam int NV = 15;
  vec_t       vecs [NV];
  logic [5:0] known_ops [6];
  logic [5:0] legal_fns [7];

  int checks = 0;
  int errors = 0;

  // Reference: ALU code for an R-type Funct, -1 when unsupported.
  function automatic int ref_aluop(input logic [5:0] fn);
    case (fn)
      6'h20:   return 0;
      6'h22:   return 2;
      6'h24:   return 4;
      6'h25:   return 5;
      6'h26:   return 6;
      6'h27:   return 7;
      6'h2A:   return 10;
      default: return -1;
    endcase
  endfunction

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h23:   return C_LW;
      6'h2B:   return C_SW;
      6'h04:   return C_BEQ;
      6'h08:   return C_ADDI;
      6'h02:   return C_J;
      6'h00:   return (ref_aluop(fn) >= 0) ? C_R : C_ILL;
      default: return C_ILL;
    endcase
  endfunction

  // Cycles per instruction, FETCH through last state.
  function automatic int ref_len(input iclass_t c);
    case (c)
      C_LW:    return 5;
      C_SW, C_R, C_ADDI: return 4;
      C_BEQ, C_J: return 3;
      default: return 2;
    endcase
  endfunction

  // The k-th step of an instruction's walk through the datapath.
  function automatic state_t ref_step(input iclass_t c, input int k);
    if (k == 0) return S_FETCH;
    if (k == 1) return S_DECODE;
    case (c)
      C_LW:    return (k == 2) ? S_MEMADR : (k == 3) ? S_MEMRD : S_MEMWB;
      C_SW:    return (k == 2) ? S_MEMADR : S_MEMWR;
      C_R:     return (k == 2) ? S_EXECUTE : S_ALUWB;
      C_ADDI:  return (k == 2) ? S_ADDIEX : S_ADDIWB;
      C_BEQ:   return S_BRANCH;
      C_J:     return S_JUMP;
      default: return S_FETCH;
    endcase
  endfunction

  // Expected outputs for a step: everything off / ADD, plus that step's deviations.
  function automatic obs_t ref_out(input state_t s, input logic [5:0] fn, input logic z,
                                   input iclass_t c);
    obs_t e;
    e = '0;
    e.state = s;
    case (s)
      S_FETCH:   begin e.irwrite = 1'b1; e.pcen = 1'b1; e.alusrcb = 2'b01; end
      S_DECODE:  begin e.alusrcb = 2'b11; e.illegal = (c == C_ILL); end
      S_MEMADR:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      S_MEMRD:   e.iord = 1'b1;
      S_MEMWB:   begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
      S_MEMWR:   begin e.iord = 1'b1; e.memwrite = 1'b1; end
      S_EXECUTE: begin e.alusrca = 1'b1; e.aluop = 4'(ref_aluop(fn)); end
      S_ALUWB:   begin e.regdst = 1'b1; e.regwrite = 1'b1; end
      S_BRANCH:  begin e.alusrca = 1'b1; e.aluop = 4'b0010; e.pcsrc = 2'b01; e.pcen = ~z; end
      S_ADDIEX:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      S_ADDIWB:  e.regwrite = 1'b1;
      S_JUMP:    begin e.pcsrc = 2'b10; e.pcen = 1'b1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = {State, IorD, MemWrite, IRWrite, PCEn, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, PCSrc, ALUOp, Illegal};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got state=%0d outs=%h, required state=%0d outs=%h",
               name, act.state, act, exp.state, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Run one instruction from FETCH until the DUT returns to FETCH (bounded).
  // zmode: 0/1 fixed Z, 2 random Z every cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                           output int cycles, output int ill_cycles, output logic [3:0] exec_op);
    iclass_t c;
    logic    z;
    bit      done;
    c          = classify(op, fn);
    cycles     = 0;
    ill_cycles = 0;
    exec_op    = 4'h0;
    done       = 1'b0;
    Opcode     = op;
    Funct      = fn;
    while (!done) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      Z = z;
      @(negedge CLK);
      if (Illegal) ill_cycles++;
      if (State == 4'(S_EXECUTE)) exec_op = ALUOp;
      if (cycles < ref_len(c))
        check_obs($sformatf("op%02h fn%02h cyc%0d", op, fn, cycles),
                  ref_out(ref_step(c, cycles), fn, z, c));
      @(posedge CLK);
      #1;
      cycles++;
      if (State == 4'(S_FETCH) || cycles >= 12) done = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc, ill, total;
    logic [3:0] xop;
    logic [5:0] op, fn;

    // op, fn, z, cycles, EXECUTE ALUOp, Illegal pulses
    vecs[0]  = '{6'h23, 6'h00, 1'b0, 4'd5, 4'h0, 1'b0};  // lw
    vecs[1]  = '{6'h2B, 6'h00, 1'b0, 4'd4, 4'h0, 1'b0};  // sw
    vecs[2]  = '{6'h00, 6'h20, 1'b0, 4'd4, 4'h0, 1'b0};  // add
    vecs[3]  = '{6'h00, 6'h22, 1'b0, 4'd4, 4'h2, 1'b0};  // sub
    vecs[4]  = '{6'h00, 6'h24, 1'b0, 4'd4, 4'h4, 1'b0};  // and
    vecs[5]  = '{6'h00, 6'h25, 1'b0, 4'd4, 4'h5, 1'b0};  // or
    vecs[6]  = '{6'h00, 6'h26, 1'b0, 4'd4, 4'h6, 1'b0};  // xor
    vecs[7]  = '{6'h00, 6'h27, 1'b0, 4'd4, 4'h7, 1'b0};  // nor
    vecs[8]  = '{6'h00, 6'h2A, 1'b0, 4'd4, 4'hA, 1'b0};  // slt
    vecs[9]  = '{6'h04, 6'h00, 1'b0, 4'd3, 4'h0, 1'b0};  // beq taken
    vecs[10] = '{6'h04, 6'h00, 1'b1, 4'd3, 4'h0, 1'b0};  // beq not taken
    vecs[11] = '{6'h08, 6'h00, 1'b0, 4'd4, 4'h0, 1'b0};  // addi
    vecs[12] = '{6'h02, 6'h00, 1'b0, 4'd3, 4'h0, 1'b0};  // j
    vecs[13] = '{6'h3F, 6'h00, 1'b0, 4'd2, 4'h0, 1'b1};  // bad opcode
    vecs[14] = '{6'h00, 6'h00, 1'b0, 4'd2, 4'h0, 1'b1};  // bad funct

    known_ops[0] = 6'h23; known_ops[1] = 6'h2B; known_ops[2] = 6'h00;
    known_ops[3] = 6'h04; known_ops[4] = 6'h08; known_ops[5] = 6'h02;
    legal_fns[0] = 6'h20; legal_fns[1] = 6'h22; legal_fns[2] = 6'h24; legal_fns[3] = 6'h25;
    legal_fns[4] = 6'h26; legal_fns[5] = 6'h27; legal_fns[6] = 6'h2A;

    // Reset: FETCH outputs while held.
    RESET  = 1'b1;
    Opcode = 6'h00;
    Funct  = 6'h00;
    Z      = 1'b0;
    @(negedge CLK);
    check_obs("reset outputs", ref_out(S_FETCH, 6'h00, 1'b0, C_LW));
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      run_instr(vecs[i].op, vecs[i].fn, int'(vecs[i].z), cyc, ill, xop);
      check_val($sformatf("vec%0d cycles", i), cyc, int'(vecs[i].cycles));
      check_val($sformatf("vec%0d illegal pulses", i), ill, int'(vecs[i].illegal));
      check_val($sformatf("vec%0d exec aluop", i), int'(xop), int'(vecs[i].exec_op));
    end

    // sw followed by j: 7 cycles total.
    run_instr(6'h2B, 6'h00, 0, cyc, ill, xop);
    total = cyc;
    run_instr(6'h02, 6'h00, 0, cyc, ill, xop);
    total += cyc;
    check_val("sw+j total cycles", total, 7);

    // Reset asserted asynchronously in the middle of lw's MEMRD.
    Opcode = 6'h23;
    Funct  = 6'h00;
    Z      = 1'b0;
    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    check_val("lw reaches MEMRD", int'(State), int'(S_MEMRD));
    #2;
    RESET = 1'b1;
    #1;
    check_val("async reset state", int'(State), int'(S_FETCH));
    check_val("async reset RegWrite", int'(RegWrite), 0);
    check_val("async reset MemWrite", int'(MemWrite), 0);
    repeat (2) begin
      @(negedge CLK);
      check_obs("reset hold", ref_out(S_FETCH, 6'h23, 1'b0, C_LW));
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    check_val("after reset release", int'(State), int'(S_FETCH));
    run_instr(6'h23, 6'h00, 0, cyc, ill, xop);
    check_val("lw after reset cycles", cyc, 5);

    // Random instruction stream against the reference model.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) < 7) op = known_ops[$urandom_range(0, 5)];
      else                          op = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 3) != 0) fn = legal_fns[$urandom_range(0, 6)];
      else                                          fn = 6'($urandom);
      run_instr(op, fn, 2, cyc, ill, xop);
      check_val($sformatf("rand%0d op%02h fn%02h cycles", n, op, fn), cyc,
                ref_len(classify(op, fn)));
      check_val($sformatf("rand%0d illegal pulses", n), ill,
                (classify(op, fn) == C_ILL) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
